// File: rtl/psk_pkg.sv
// Shared definitions for the PSK symbol framer: FSM encoding, symbols per byte,
// and the default preamble.
package psk_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2
  } state_t;

  localparam int SYM_BPSK = 8;
  localparam int SYM_QPSK = 4;

  localparam logic [31:0] PREAMBLE_DEFAULT = 32'h0000_F35A;

endpackage

// File: rtl/psk_byte_serializer.sv
// Byte-in / symbol-out serializer: shifts one payload byte out MSB-first as
// 1-bit (BPSK) or 2-bit (QPSK) symbols.
module psk_byte_serializer
  import psk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_bpsk,
  input  logic [7:0] byte_data,
  input  logic       byte_load,
  input  logic       byte_last,
  input  logic       sym_take,
  output logic       byte_ready,
  output logic       sym_avail,
  output logic       sym_last,
  output logic [1:0] sym_bits
);

  logic [7:0] sr;
  logic [3:0] sym_left;
  logic       last_byte;

  assign sym_avail = (sym_left != 4'd0);
  assign sym_last  = (sym_left == 4'd1) && last_byte;
  assign sym_bits  = mode_bpsk ? {sr[7], sr[7]} : sr[7:6];

  // Accepting on the final symbol's handshake keeps bytes back-to-back; the
  // frame's last byte never lets a follow-on byte in.
  assign byte_ready = (sym_left == 4'd0) ||
                      ((sym_left == 4'd1) && sym_take && !last_byte);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      sym_left  <= '0;
      last_byte <= 1'b0;
    end else if (byte_load) begin
      sr        <= byte_data;
      sym_left  <= mode_bpsk ? 4'(SYM_BPSK) : 4'(SYM_QPSK);
      last_byte <= byte_last;
    end else if (sym_take && sym_avail) begin
      sr       <= mode_bpsk ? {sr[6:0], 1'b0} : {sr[5:0], 2'b00};
      sym_left <= sym_left - 4'd1;
    end
  end

endmodule

// File: rtl/psk_symbol_framer.sv
// Frames a byte AXIS payload into per-symbol AXIS beats: BPSK preamble first,
// then the payload serialised MSB-first in the mode latched at frame start.
module psk_symbol_framer
  import psk_pkg::*;
#(
  parameter int          BYTES        = 1,
  parameter int          PREAMBLE_LEN = 16,
  parameter logic [31:0] PREAMBLE_SEQ = PREAMBLE_DEFAULT
) (
  input  logic               clk_16M384,
  input  logic               rst_16M384,
  input  logic [7:0]         in_tdata,
  input  logic               in_tvalid,
  output logic               in_tready,
  input  logic               in_tlast,
  input  logic               cfg_is_bpsk,
  output logic [BYTES*8-1:0] out_tdata,
  output logic               out_tvalid,
  input  logic               out_tready,
  output logic               out_tlast,
  output logic               out_tuser,
  output logic               busy,
  output logic               underrun,
  output logic [15:0]        frame_cnt
);

  localparam logic [4:0] LAST_IDX = 5'(PREAMBLE_LEN - 1);

  state_t     state, state_nxt;
  logic       mode_bpsk;
  logic [4:0] pre_idx;
  logic       pre_bit;
  logic       out_hs;

  logic       ser_ready, ser_avail, ser_last, ser_take;
  logic [1:0] ser_bits;

  assign pre_bit  = PREAMBLE_SEQ[LAST_IDX - pre_idx];
  assign out_hs   = out_tvalid && out_tready;
  assign ser_take = (state == PAYLOAD) && out_tready && ser_avail;
  assign busy     = (state != IDLE);

  psk_byte_serializer u_ser (
    .clk        (clk_16M384),
    .rst        (rst_16M384),
    .mode_bpsk  (mode_bpsk),
    .byte_data  (in_tdata),
    .byte_load  (in_tvalid && in_tready),
    .byte_last  (in_tlast),
    .sym_take   (ser_take),
    .byte_ready (ser_ready),
    .sym_avail  (ser_avail),
    .sym_last   (ser_last),
    .sym_bits   (ser_bits)
  );

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    out_tvalid = 1'b0;
    out_tdata  = '0;
    out_tuser  = 1'b0;
    out_tlast  = 1'b0;
    in_tready  = 1'b0;
    case (state)
      IDLE: begin
        if (in_tvalid) state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
        out_tvalid     = 1'b1;
        out_tdata[1:0] = {pre_bit, pre_bit};
        out_tuser      = 1'b1;
        if (out_hs && pre_idx == LAST_IDX) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        out_tvalid = ser_avail;
        if (ser_avail) out_tdata[1:0] = ser_bits;
        out_tuser  = mode_bpsk;
        out_tlast  = ser_last;
        in_tready  = ser_ready;
        if (out_hs && ser_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      mode_bpsk <= 1'b0;
      pre_idx   <= '0;
      frame_cnt <= '0;
      underrun  <= 1'b0;
    end else begin
      // Starvation is flagged one cycle late so the output stays registered.
      underrun <= (state == PAYLOAD) && !ser_avail && !in_tvalid;
      if (state == IDLE && in_tvalid) begin
        mode_bpsk <= cfg_is_bpsk;
        pre_idx   <= '0;
      end
      if (state == PREAMBLE && out_hs) pre_idx <= pre_idx + 5'd1;
      if (state == PAYLOAD && out_hs && ser_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
